// File: rtl/exception_ctrl.sv
// Exception arbiter feeding cp0: prioritises MEM-stage exception flags and
// pending interrupts, then issues a registered exception record plus a one-cycle flush.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_sync_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [8:0]  mem_excflags_i,
    input  logic [31:0] mem_data_addr_i,
    input  logic        stall_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam int F_ADEL_IF = 0;
    localparam int F_RI      = 1;
    localparam int F_SYS     = 2;
    localparam int F_BRK     = 3;
    localparam int F_OV      = 4;
    localparam int F_TRAP    = 5;
    localparam int F_ADEL_D  = 6;
    localparam int F_ADES_D  = 7;
    localparam int F_ERET    = 8;

    localparam logic [31:0] CODE_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        ISSUE,
        FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;

    logic [31:0] status_f, cause_f, epc_f;
    logic        int_pending;
    logic [31:0] det_code, det_bad;
    logic        detect;

    logic [31:0] rec_code_q, rec_code_d;
    logic [31:0] rec_pc_q, rec_pc_d;
    logic        rec_ds_q, rec_ds_d;
    logic [31:0] rec_bad_q, rec_bad_d;

    logic [31:0] exc_q, exc_d;
    logic [31:0] addr_q, addr_d;
    logic        ds_q, ds_d;
    logic [31:0] bad_q, bad_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic unused_bits;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], int_i};
    end

    assign int_sync_o = {sync_q[SYNC_STAGES-1][5] | timer_int_i, sync_q[SYNC_STAGES-1][4:0]};

    // An mtc0 retiring in WB this cycle has not reached cp0 yet, so bypass it.
    always_comb begin
        status_f = status_i;
        cause_f  = cause_i;
        epc_f    = epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                5'd12: status_f = wb_cp0_wdata_i;
                5'd13: cause_f  = {cause_i[31:24], wb_cp0_wdata_i[23:22], cause_i[21:10],
                                   wb_cp0_wdata_i[9:8], cause_i[7:0]};
                5'd14: epc_f    = wb_cp0_wdata_i;
                default: ;
            endcase
        end
    end

    assign int_pending = status_f[0] & ~status_f[1] & (|(cause_f[15:8] & status_f[15:8]));

    always_comb begin
        det_code = 32'h0;
        det_bad  = 32'h0;
        if (int_pending) begin
            det_code = 32'h01;
        end else if (mem_excflags_i[F_ADEL_IF]) begin
            det_code = 32'h04;
            det_bad  = mem_pc_i;
        end else if (mem_excflags_i[F_RI]) begin
            det_code = 32'h0a;
        end else if (mem_excflags_i[F_OV]) begin
            det_code = 32'h0c;
        end else if (mem_excflags_i[F_TRAP]) begin
            det_code = 32'h0d;
        end else if (mem_excflags_i[F_SYS]) begin
            det_code = 32'h08;
        end else if (mem_excflags_i[F_BRK]) begin
            det_code = 32'h09;
        end else if (mem_excflags_i[F_ADEL_D]) begin
            det_code = 32'h04;
            det_bad  = mem_data_addr_i;
        end else if (mem_excflags_i[F_ADES_D]) begin
            det_code = 32'h05;
            det_bad  = mem_data_addr_i;
        end else if (mem_excflags_i[F_ERET]) begin
            det_code = CODE_ERET;
        end
    end

    assign detect = mem_valid_i && (det_code != 32'h0) && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        rec_code_d = rec_code_q;
        rec_pc_d   = rec_pc_q;
        rec_ds_d   = rec_ds_q;
        rec_bad_d  = rec_bad_q;
        exc_d      = 32'h0;
        addr_d     = 32'h0;
        ds_d       = 1'b0;
        bad_d      = 32'h0;
        flush_d    = 1'b0;
        new_pc_d   = 32'h0;

        case (state_q)
            IDLE: begin
                if (detect) begin
                    rec_code_d = det_code;
                    rec_pc_d   = mem_pc_i;
                    rec_ds_d   = mem_in_delayslot_i;
                    rec_bad_d  = det_bad;
                    state_d    = stall_i ? HOLD : ISSUE;
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // rec_*_d already holds the live detection on the IDLE->ISSUE path.
        if (state_d == ISSUE) begin
            exc_d    = rec_code_d;
            addr_d   = rec_pc_d;
            ds_d     = rec_ds_d;
            bad_d    = rec_bad_d;
            flush_d  = 1'b1;
            new_pc_d = (rec_code_d == CODE_ERET) ? epc_f : EXC_VECTOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            rec_code_q <= 32'h0;
            rec_pc_q   <= 32'h0;
            rec_ds_q   <= 1'b0;
            rec_bad_q  <= 32'h0;
            exc_q      <= 32'h0;
            addr_q     <= 32'h0;
            ds_q       <= 1'b0;
            bad_q      <= 32'h0;
            flush_q    <= 1'b0;
            new_pc_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rec_code_q <= rec_code_d;
            rec_pc_q   <= rec_pc_d;
            rec_ds_q   <= rec_ds_d;
            rec_bad_q  <= rec_bad_d;
            exc_q      <= exc_d;
            addr_q     <= addr_d;
            ds_q       <= ds_d;
            bad_q      <= bad_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
        end
    end

    assign excepttype_o        = exc_q;
    assign current_inst_addr_o = addr_q;
    assign is_in_delayslot_o   = ds_q;
    assign bad_addr_o          = bad_q;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;

    assign unused_bits = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: priority, forwarding, stall hold,
// interrupt synchroniser and reset behaviour, checked with immediate assertions.
module tb_exception_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [5:0]  int_sync_o;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [8:0]  mem_excflags_i;
    logic [31:0] mem_data_addr_i;
    logic        stall_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int checkCount;
    int passCount;

    exception_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_i               (int_i),
        .timer_int_i         (timer_int_i),
        .int_sync_o          (int_sync_o),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_excflags_i      (mem_excflags_i),
        .mem_data_addr_i     (mem_data_addr_i),
        .stall_i             (stall_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_wdata_i      (wb_cp0_wdata_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [8:0] flags,
                                 input logic [31:0] daddr, input logic stall);
        mem_valid_i     = valid;
        mem_pc_i        = pc;
        mem_excflags_i  = flags;
        mem_data_addr_i = daddr;
        stall_i         = stall;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " excepttype"}, excepttype_o, 32'h0);
        checkOutput({tag, " flush"}, {31'h0, flush_o}, 32'h0);
    endtask

    initial begin
        checkCount         = 0;
        passCount          = 0;
        rst                = 1'b1;
        int_i              = 6'h0;
        timer_int_i        = 1'b0;
        mem_in_delayslot_i = 1'b0;
        status_i           = 32'h0;
        cause_i            = 32'h0;
        epc_i              = 32'h0;
        wb_cp0_we_i        = 1'b0;
        wb_cp0_waddr_i     = 5'd0;
        wb_cp0_wdata_i     = 32'h0;
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);

        #12;
        checkIdle("reset");
        checkOutput("reset new_pc", new_pc_o, 32'h0);
        checkOutput("reset int_sync", {26'h0, int_sync_o}, 32'h0);
        rst = 1'b0;

        $display("[TB] overflow exception");
        applyStimulus(1'b1, 32'hBFC00100, 9'h010, 32'h0, 1'b0);
        tick();
        checkOutput("ov excepttype", excepttype_o, 32'h0C);
        checkOutput("ov addr", current_inst_addr_o, 32'hBFC00100);
        checkOutput("ov flush", {31'h0, flush_o}, 32'h1);
        checkOutput("ov new_pc", new_pc_o, 32'hBFC00380);
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        tick();
        checkIdle("ov after");
        checkOutput("ov after new_pc", new_pc_o, 32'h0);
        tick();

        $display("[TB] priority");
        applyStimulus(1'b1, 32'hBFC00104, 9'h016, 32'h0, 1'b0);
        tick();
        checkOutput("ri>ov>sys excepttype", excepttype_o, 32'h0A);
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        tick();
        tick();
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        applyStimulus(1'b1, 32'hBFC00108, 9'h016, 32'h0, 1'b0);
        tick();
        checkOutput("int excepttype", excepttype_o, 32'h01);
        checkOutput("int addr", current_inst_addr_o, 32'hBFC00108);
        checkOutput("int bad_addr", bad_addr_o, 32'h0);
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        status_i = 32'h0;
        cause_i  = 32'h0;
        tick();
        tick();

        $display("[TB] eret with forwarded epc");
        epc_i              = 32'h80001000;
        wb_cp0_we_i        = 1'b1;
        wb_cp0_waddr_i     = 5'd14;
        wb_cp0_wdata_i     = 32'h80002000;
        mem_in_delayslot_i = 1'b1;
        applyStimulus(1'b1, 32'hBFC0010C, 9'h100, 32'h0, 1'b0);
        tick();
        checkOutput("eret excepttype", excepttype_o, 32'h0E);
        checkOutput("eret new_pc", new_pc_o, 32'h80002000);
        checkOutput("eret delayslot", {31'h0, is_in_delayslot_o}, 32'h1);
        wb_cp0_we_i        = 1'b0;
        mem_in_delayslot_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        tick();
        tick();

        $display("[TB] adel_d held by stall");
        applyStimulus(1'b1, 32'hBFC00200, 9'h040, 32'h1003, 1'b1);
        tick();
        checkIdle("hold1");
        applyStimulus(1'b1, 32'hBFC00300, 9'h010, 32'h2000, 1'b1);
        tick();
        checkIdle("hold2");
        tick();
        checkIdle("hold3");
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        tick();
        checkOutput("adel_d excepttype", excepttype_o, 32'h04);
        checkOutput("adel_d bad_addr", bad_addr_o, 32'h1003);
        checkOutput("adel_d addr", current_inst_addr_o, 32'hBFC00200);
        checkOutput("adel_d flush", {31'h0, flush_o}, 32'h1);
        tick();
        checkIdle("adel_d after");
        tick();

        $display("[TB] interrupt synchroniser");
        int_i = 6'h01;
        tick();
        checkOutput("sync stage1", {26'h0, int_sync_o}, 32'h0);
        int_i = 6'h00;
        tick();
        checkOutput("sync stage2", {26'h0, int_sync_o}, 32'h01);
        tick();
        checkOutput("sync pulse end", {26'h0, int_sync_o}, 32'h0);
        timer_int_i = 1'b1;
        #1;
        checkOutput("timer bit5", {26'h0, int_sync_o}, 32'h20);
        timer_int_i = 1'b0;
        status_i = 32'h0000_0403;
        cause_i  = 32'h0000_0400;
        applyStimulus(1'b1, 32'hBFC00110, 9'h0, 32'h0, 1'b0);
        tick();
        checkIdle("exl masks int");
        status_i = 32'h0;
        cause_i  = 32'h0;
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        tick();

        $display("[TB] reset during HOLD and ISSUE");
        applyStimulus(1'b1, 32'hBFC00400, 9'h001, 32'h0, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        checkIdle("rst hold");
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        tick();
        checkIdle("post rst 1");
        tick();
        checkIdle("post rst 2");
        applyStimulus(1'b1, 32'hBFC00400, 9'h001, 32'h0, 1'b0);
        tick();
        checkOutput("adel_if excepttype", excepttype_o, 32'h04);
        checkOutput("adel_if bad_addr", bad_addr_o, 32'hBFC00400);
        applyStimulus(1'b0, 32'h0, 9'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        checkIdle("rst issue");
        checkOutput("rst issue new_pc", new_pc_o, 32'h0);
        rst = 1'b0;
        tick();
        checkIdle("post rst 3");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
